// File: rtl/shared_reg_pkg.sv
// Shared types, defaults and width helpers for the shared-register arbiter.
package shared_reg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Index width that never collapses to zero bits for tiny counts.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin winner search starting at ptr and wrapping modulo N_REQ.
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    idx,
  output logic             found
);

  localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW:0]        sum;

  // rot[k] is req[(ptr + k) mod N_REQ]: rotating a doubled copy avoids a modulo per bit.
  assign dbl   = {req, req} >> ptr;
  assign rot   = dbl[N_REQ-1:0];
  assign found = |req;

  always_comb begin
    idx = '0;
    sum = '0;
    // Descending scan so the lowest rotated offset is the one that sticks.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, ptr} + (IW+1)'(k);
        idx = (sum >= N_W) ? IW'(sum - N_W) : sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of one shared register: grants a requester, loads its lane each cycle,
// and hands off after MAX_HOLD writes or when the owner drops its request.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter  int N_REQ    = DEF_N_REQ,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IW       = idx_w(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        grant,
  output logic [IW-1:0]           owner,
  output logic                    busy,
  output logic [DATA_W-1:0]       q,
  output logic                    q_upd
);

  localparam int HW = idx_w(MAX_HOLD + 1);

  // Handshake: req[i] is a level request; grant is registered and one-hot while owning,
  // and the owner's lane is written at every edge where its req is still high.
  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [DATA_W-1:0]   q_q, q_d;
  logic                q_upd_q, q_upd_d;

  logic [DATA_W-1:0]   lane [N_REQ];
  logic [IW-1:0]       next_ptr;
  logic [IW-1:0]       pick_ptr;
  logic [IW-1:0]       pick_idx;
  logic                pick_found;
  logic                own_req;
  logic                wr_en;
  logic                last_wr;
  logic                release_own;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane[g] = wr_data[g*DATA_W +: DATA_W];
  end

  assign own_req     = req[owner_q];
  assign wr_en       = (state_q == OWN) && own_req;
  assign last_wr     = (hold_q == HW'(MAX_HOLD - 1));
  assign release_own = (state_q == OWN) && (!own_req || last_wr);
  assign next_ptr    = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // While owning, the only pick that matters is the hand-off one, which starts after the owner.
  assign pick_ptr = (state_q == OWN) ? next_ptr : ptr_q;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    q_d     = wr_en ? lane[owner_q] : q_q;
    q_upd_d = wr_en;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          owner_d = pick_idx;
          hold_d  = '0;
        end
      end
      OWN: begin
        if (wr_en) begin
          hold_d = hold_q + 1'b1;
        end
        if (release_own) begin
          ptr_d  = next_ptr;
          hold_d = '0;
          if (pick_found) begin
            grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      q_q     <= '0;
      q_upd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      q_q     <= q_d;
      q_upd_q <= q_upd_d;
    end
  end

  // busy is the FSM state itself, so it doubles as the state debug view.
  assign busy  = (state_q == OWN);
  assign grant = grant_q;
  assign owner = owner_q;
  assign q     = q_q;
  assign q_upd = q_upd_q;

endmodule
